// File: rtl/gr8ram_ctl.sv
// GR8RAM Apple II slot card controller: bus-phase sequencer, address/control
// registers with auto-increment, muxed DRAM timing with CAS-before-RAS refresh, ROM select.
module gr8ram_ctl #(
  parameter int unsigned RA_W    = 11,
  parameter int unsigned CS_W    = 1,
  parameter int unsigned REF_DIV = 13
) (
  input  logic                 C7M,
  input  logic                 RES,
  input  logic                 PHI1,
  input  logic                 nDEVSEL,
  input  logic                 nIOSEL,
  input  logic                 nIOSTRB,
  input  logic [10:0]          A,
  input  logic                 nWE,
  input  logic [7:0]           Din,
  input  logic [7:0]           RDin,
  output logic [7:0]           Dout,
  output logic                 DOE,
  output logic                 RDOE,
  output logic [RA_W-1:0]      RA,
  output logic                 nRAS,
  output logic [2**CS_W-1:0]   nCAS,
  output logic                 nRWE,
  output logic                 nRCS,
  output logic [7:0]           ROMBANK
);

  localparam int unsigned NBANK  = 2**CS_W;
  localparam int unsigned ADDR_W = 2*RA_W + CS_W;
  localparam int unsigned REF_W  = (REF_DIV > 1) ? $clog2(REF_DIV) : 1;

  logic [2:0]        s, s_nxt;
  logic              phi1reg, phi0seen;
  logic              dben, csen, regen, iromen;
  logic              incpend, inc_en, dec, casel;
  logic [REF_W-1:0]  refcnt;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        bank;
  logic [31:0]       addr32, addr_wr;
  logic [CS_W-1:0]   chip;
  logic              regsel, ramrd, ramwr, refresh;
  logic              ras_nxt, rwe_nxt, casel_nxt;
  logic [NBANK-1:0]  cas_nxt;

  assign addr32  = 32'(addr);
  assign chip    = addr[ADDR_W-1 -: CS_W];
  assign regsel  = !nDEVSEL && regen;
  assign ramrd   = regsel && (A[3:0] == 4'h3) && nWE;
  assign ramwr   = regsel && (A[3:0] == 4'h3) && !nWE;
  assign refresh = (refcnt == '0);

  always_comb begin
    if (PHI1 && !phi1reg && phi0seen) s_nxt = 3'd1;
    else if (s == 3'd0 || s == 3'd7)  s_nxt = s;
    else                               s_nxt = s + 3'd1;
  end

  // DRAM strobes are registered, so they are decoded from the state being entered.
  always_comb begin
    ras_nxt   = 1'b1;
    cas_nxt   = '1;
    rwe_nxt   = 1'b1;
    casel_nxt = 1'b0;
    if (refresh && (s_nxt == 3'd2 || s_nxt == 3'd3)) cas_nxt = '0;
    if (refresh && s_nxt == 3'd3) ras_nxt = 1'b0;
    if (ramrd && s_nxt >= 3'd5) ras_nxt = 1'b0;
    if (ramrd && s_nxt >= 3'd6) begin
      casel_nxt     = 1'b1;
      cas_nxt[chip] = 1'b0;
    end
    if (ramwr && s_nxt >= 3'd6) ras_nxt = 1'b0;
    if (ramwr && s_nxt == 3'd7) begin
      casel_nxt     = 1'b1;
      cas_nxt[chip] = 1'b0;
      rwe_nxt       = 1'b0;
    end
  end

  // Byte writes go through a 32-bit view so bits above ADDR_W drop out.
  always_comb begin
    addr_wr = addr32;
    case (A[3:0])
      4'h0:    addr_wr[7:0]   = Din;
      4'h1:    addr_wr[15:8]  = Din;
      4'h2:    addr_wr[23:16] = Din;
      4'h4:    addr_wr[31:24] = Din;
      default: ;
    endcase
  end

  always_ff @(posedge C7M) begin
    if (RES) begin
      s        <= '0;
      phi1reg  <= 1'b0;
      phi0seen <= 1'b0;
      refcnt   <= '0;
      dben     <= 1'b0;
      csen     <= 1'b0;
      regen    <= 1'b0;
      iromen   <= 1'b0;
      addr     <= '0;
      bank     <= '0;
      incpend  <= 1'b0;
      inc_en   <= 1'b1;
      dec      <= 1'b0;
      casel    <= 1'b0;
      nRAS     <= 1'b1;
      nCAS     <= '1;
      nRWE     <= 1'b1;
    end else begin
      phi1reg <= PHI1;
      if (!PHI1) phi0seen <= 1'b1;
      s    <= s_nxt;
      dben <= (s >= 3'd4);
      csen <= (s == 3'd4 && nWE) || (s >= 3'd5);
      if (s == 3'd3)
        refcnt <= (refcnt == REF_W'(REF_DIV - 1)) ? '0 : refcnt + 1'b1;
      if (s == 3'd4 && !nIOSEL) begin
        regen  <= 1'b1;
        iromen <= 1'b1;
      end
      if (s == 3'd4 && !nIOSTRB && A == 11'h7FF) iromen <= 1'b0;
      nRAS  <= ras_nxt;
      nCAS  <= cas_nxt;
      nRWE  <= rwe_nxt;
      casel <= casel_nxt;
      if (s == 3'd1 && incpend) begin
        addr    <= dec ? addr - 1'b1 : addr + 1'b1;
        incpend <= 1'b0;
      end
      if (s == 3'd6 && regsel) begin
        if (!nWE) begin
          incpend <= 1'b0;
          case (A[3:0])
            4'h0, 4'h1, 4'h2, 4'h4: addr <= addr_wr[ADDR_W-1:0];
            4'hE: begin
              inc_en <= Din[0];
              dec    <= Din[1];
            end
            4'hF:    bank <= Din;
            default: ;
          endcase
        end
        if (A[3:0] == 4'h3 && inc_en) incpend <= 1'b1;
      end
    end
  end

  always_comb begin
    Dout = RDin;
    if (!nDEVSEL) begin
      case (A[3:0])
        4'h0:    Dout = addr32[7:0];
        4'h1:    Dout = addr32[15:8];
        4'h2:    Dout = addr32[23:16];
        4'h3:    Dout = RDin;
        4'h4:    Dout = addr32[31:24];
        4'hE:    Dout = {6'b0, dec, inc_en};
        4'hF:    Dout = bank;
        default: Dout = 8'h00;
      endcase
    end
  end

  assign DOE     = dben && nWE && ((!nDEVSEL && regen) || !nIOSEL || (!nIOSTRB && iromen));
  assign RDOE    = dben && !nWE;
  assign nRCS    = !((!nIOSEL || (!nIOSTRB && iromen)) && csen);
  assign RA      = casel ? addr[RA_W-1:0] : addr[2*RA_W-1:RA_W];
  assign ROMBANK = bank;

endmodule

// File: tb/tb_gr8ram_ctl.sv
// Directed bench for gr8ram_ctl: bus cycles are generated from a bench-side S count,
// strobes are captured per state and compared against hand-derived patterns.
module tb_gr8ram_ctl;

  logic        C7M = 1'b0, RES = 1'b1, PHI1 = 1'b0;
  logic        nDEVSEL = 1'b1, nIOSEL = 1'b1, nIOSTRB = 1'b1, nWE = 1'b1;
  logic [10:0] A = '0;
  logic [7:0]  Din = '0, RDin = 8'hA5;
  logic [7:0]  Dout, ROMBANK;
  logic        DOE, RDOE, nRAS, nRWE, nRCS;
  logic [10:0] RA;
  logic [1:0]  nCAS;

  int unsigned n_chk = 0, n_fail = 0, bst = 0, bc = 0;
  logic [6:0]  ob_ras, ob_cas0, ob_cas1, ob_rwe;
  logic [10:0] ob_ra [1:7];
  logic [7:0]  ob_dout;
  logic        ob_doe, ob_rdoe, ob_rcs, ob_ref, act;

  gr8ram_ctl #(.RA_W(11), .CS_W(1), .REF_DIV(13)) dut (
    .C7M(C7M), .RES(RES), .PHI1(PHI1), .nDEVSEL(nDEVSEL), .nIOSEL(nIOSEL),
    .nIOSTRB(nIOSTRB), .A(A), .nWE(nWE), .Din(Din), .RDin(RDin),
    .Dout(Dout), .DOE(DOE), .RDOE(RDOE), .RA(RA), .nRAS(nRAS), .nCAS(nCAS),
    .nRWE(nRWE), .nRCS(nRCS), .ROMBANK(ROMBANK)
  );

  always #5 C7M = ~C7M;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge C7M);
    #1;
  endtask

  task automatic idle();
    PHI1 = 1'b0;
    bst  = 0;
    step();
  endtask

  task automatic adv();
    bst  = (bst == 0 || bst == 7) ? 1 : bst + 1;
    PHI1 = (bst <= 3);
    step();
  endtask

  // One full bus cycle S1..S7; selects are presented from S4 on.
  task automatic bus(input logic dv, input logic io, input logic stb,
                     input logic [10:0] a, input logic we_n, input logic [7:0] d);
    ob_ref = (bc % 13 == 0);
    bc++;
    for (int k = 1; k <= 7; k++) begin
      if (k == 4) begin
        nDEVSEL = ~dv; nIOSEL = ~io; nIOSTRB = ~stb;
        A = a; nWE = we_n; Din = d;
      end
      adv();
      ob_ras[k-1]  = nRAS;
      ob_cas0[k-1] = nCAS[0];
      ob_cas1[k-1] = nCAS[1];
      ob_rwe[k-1]  = nRWE;
      ob_ra[k]     = RA;
    end
    ob_dout = Dout; ob_doe = DOE; ob_rdoe = RDOE; ob_rcs = nRCS;
    nDEVSEL = 1'b1; nIOSEL = 1'b1; nIOSTRB = 1'b1; nWE = 1'b1;
  endtask

  task automatic wr(input logic [3:0] off, input logic [7:0] d);
    bus(1'b1, 1'b0, 1'b0, {7'd0, off}, 1'b0, d);
  endtask

  task automatic rd(input string tag, input logic [3:0] off, input logic [31:0] exp);
    bus(1'b1, 1'b0, 1'b0, {7'd0, off}, 1'b1, 8'h00);
    check(tag, 32'(ob_dout), exp);
  endtask

  task automatic chk_bus(input string tag, input logic [6:0] ras, input logic [6:0] c0,
                         input logic [6:0] c1, input logic [6:0] rwe);
    logic [6:0] rm, cm;
    rm = ob_ref ? 7'b1111011 : 7'h7F;
    cm = ob_ref ? 7'b1111001 : 7'h7F;
    check({tag, ".ras"},  32'(ob_ras),  32'(ras & rm));
    check({tag, ".cas0"}, 32'(ob_cas0), 32'(c0 & cm));
    check({tag, ".cas1"}, 32'(ob_cas1), 32'(c1 & cm));
    check({tag, ".rwe"},  32'(ob_rwe),  32'(rwe));
  endtask

  initial begin
    step(); step();
    check("rst.nras", 32'(nRAS), 'h1);
    check("rst.ncas", 32'(nCAS), 'h3);
    check("rst.nrwe", 32'(nRWE), 'h1);
    check("rst.nrcs", 32'(nRCS), 'h1);
    check("rst.doe",  32'(DOE),  'h0);
    check("rst.rdoe", 32'(RDOE), 'h0);
    check("rst.ra",   32'(RA),   'h0);
    check("rst.bank", 32'(ROMBANK), 'h0);

    RES = 1'b0;
    PHI1 = 1'b1;
    act = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      act = act | !nRAS | !(&nCAS) | !nRCS;
    end
    check("nophi.quiet", 32'(act), 'h0);

    idle();
    for (int i = 0; i < 14; i++) begin
      bus(1'b0, 1'b0, 1'b0, 11'h000, 1'b1, 8'h00);
      chk_bus($sformatf("idle%0d", i), 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    end

    bus(1'b0, 1'b1, 1'b0, 11'h000, 1'b1, 8'h00);
    check("iosel.nrcs", 32'(ob_rcs), 'h0);
    check("iosel.doe",  32'(ob_doe), 'h1);
    check("iosel.dout", 32'(ob_dout), 'hA5);

    wr(4'h0, 8'h12);
    check("wr.rdoe", 32'(ob_rdoe), 'h1);
    wr(4'h1, 8'h34);
    wr(4'h2, 8'h56);
    rd("rd.addrl", 4'h0, 'h12);
    check("rd.doe", 32'(ob_doe), 'h1);
    rd("rd.addrm", 4'h1, 'h34);
    rd("rd.addrh", 4'h2, 'h56);
    rd("rd.addrx", 4'h4, 'h00);
    rd("rd.ctl",   4'hE, 'h01);
    rd("rd.off5",  4'h5, 'h00);

    rd("ram.rd.dout", 4'h3, 'hA5);
    chk_bus("ram.rd", 7'b0001111, 7'h7F, 7'b0011111, 7'h7F);
    check("ram.rd.row", 32'(ob_ra[5]), 'h2C6);
    check("ram.rd.col", 32'(ob_ra[6]), 'h412);
    rd("inc.addrl", 4'h0, 'h13);

    wr(4'h0, 8'hFF); wr(4'h1, 8'hFF); wr(4'h2, 8'h3F);
    rd("ram.rd3f", 4'h3, 'hA5);
    chk_bus("ram.rd3f", 7'b0001111, 7'b0011111, 7'h7F, 7'h7F);
    check("ram.rd3f.row", 32'(ob_ra[5]), 'h7FF);
    rd("inc.carry", 4'h2, 'h40);

    wr(4'h0, 8'hFF); wr(4'h1, 8'hFF); wr(4'h2, 8'hFF);
    rd("mask.addrh", 4'h2, 'h7F);
    wr(4'h4, 8'hFF);
    rd("mask.addrx", 4'h4, 'h00);
    rd("ram.rdtop", 4'h3, 'hA5);
    chk_bus("ram.rdtop", 7'b0001111, 7'h7F, 7'b0011111, 7'h7F);
    check("ram.rdtop.col", 32'(ob_ra[6]), 'h7FF);
    rd("wrap.addrl", 4'h0, 'h00);
    rd("wrap.addrh", 4'h2, 'h00);

    wr(4'hE, 8'h03);
    rd("ctl.dec", 4'hE, 'h03);
    wr(4'h0, 8'h00); wr(4'h1, 8'h00); wr(4'h2, 8'h00);
    wr(4'h3, 8'h5A);
    chk_bus("ram.wr", 7'b0011111, 7'b0111111, 7'h7F, 7'b0111111);
    check("ram.wr.rdoe", 32'(ob_rdoe), 'h1);
    rd("dec.addrl", 4'h0, 'hFF);
    rd("dec.addrh", 4'h2, 'h7F);
    wr(4'hE, 8'h00);
    wr(4'h3, 8'h11);
    rd("noinc.addrl", 4'h0, 'hFF);

    wr(4'hF, 8'h3C);
    check("bank.port", 32'(ROMBANK), 'h3C);
    rd("bank.rd", 4'hF, 'h3C);

    bus(1'b0, 1'b0, 1'b1, 11'h100, 1'b1, 8'h00);
    check("strb.nrcs", 32'(ob_rcs), 'h0);
    check("strb.doe",  32'(ob_doe), 'h1);
    bus(1'b0, 1'b0, 1'b1, 11'h7FF, 1'b1, 8'h00);
    check("strb7ff.nrcs", 32'(ob_rcs), 'h1);
    bus(1'b0, 1'b0, 1'b1, 11'h100, 1'b1, 8'h00);
    check("strboff.nrcs", 32'(ob_rcs), 'h1);
    check("strboff.doe",  32'(ob_doe), 'h0);

    for (int k = 1; k <= 6; k++) begin
      if (k == 4) begin
        nDEVSEL = 1'b0; A = 11'h003; nWE = 1'b1;
      end
      adv();
    end
    check("midrst.s6.nras", 32'(nRAS), 'h0);
    check("midrst.s6.ncas", 32'(nCAS), 'h1);
    RES = 1'b1;
    step();
    check("midrst.nras", 32'(nRAS), 'h1);
    check("midrst.ncas", 32'(nCAS), 'h3);
    check("midrst.ra",   32'(RA),   'h0);
    RES = 1'b0;
    nDEVSEL = 1'b1;
    bc = 0;
    idle();
    bus(1'b0, 1'b1, 1'b0, 11'h000, 1'b1, 8'h00);
    rd("midrst.addrl", 4'h0, 'h00);
    rd("midrst.ctl",   4'hE, 'h01);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
